// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the 5-stage MIPS pipeline
//                control blocks: stall sequencer states, register-zero
//                constant and the per-stage control bundle.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Stall sequencer states
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } stall_state_e;

    // Architectural register $zero; never a real data dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Per-stage register enables and flushes plus the MDU start pulse
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mdu_start;
    } stage_ctl_t;

    // Everything frozen, nothing flushed (reset)
    localparam stage_ctl_t CTL_OFF  = stage_ctl_t'(8'b0000_0000);
    // Free-running pipeline
    localparam stage_ctl_t CTL_FLOW = stage_ctl_t'(8'b1111_0000);

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctl_if
//  Description : Hazard inputs and stage-control outputs of the pipeline
//                stall sequencer. master = sequencer, slave = pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_stall_ctl_if #(
    parameter int CNT_W = 16
);
    // Hazard information from the pipeline
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_ex_memread;
    logic [4:0]       id_ex_rt;
    logic             ex_mdu_op;
    logic             pcsrc;
    logic             mdu_done;

    // Stage controls back to the pipeline
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mdu_start;
    logic             mdu_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  id_rs, id_rt, id_uses_rt, id_jump, id_ex_memread, id_ex_rt,
               ex_mdu_op, pcsrc, mdu_done,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, ex_mem_flush,
               mdu_start, mdu_err, stall_cnt
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, id_jump, id_ex_memread, id_ex_rt,
               ex_mdu_op, pcsrc, mdu_done,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, ex_mem_flush,
               mdu_start, mdu_err, stall_cnt
    );

endinterface : pipe_stall_ctl_if
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Pure combinational load-use hazard compare between the load
//                in EX and the source registers of the instruction in ID.
//  Revision    : 1.0  initial release
// ============================================================================
module load_use_detect
    import mips_pkg::*;
(
    input  wire logic       id_ex_memread,
    input  wire logic [4:0] id_ex_rt,
    input  wire logic [4:0] id_rs,
    input  wire logic [4:0] id_rt,
    input  wire logic       id_uses_rt,
    output logic            hazard
);

    // A load into $zero produces nothing to wait for
    always_comb begin
        hazard = id_ex_memread
               && (id_ex_rt != REG_ZERO)
               && ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
    end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_stall_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctl
//  Description : Central hazard/stall sequencer. Generates stage enables and
//                flushes for load-use bubbles, taken branch/jump squashes and
//                multi-cycle ALU waits; starts the MDU and aborts it on
//                timeout. Keeps a saturating count of PC-stall cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stall_ctl
    import mips_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,      // asynchronous, active-low
    pipe_stall_ctl_if.master  bus
);

    localparam int BUSY_CNT_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [BUSY_CNT_W-1:0] BUSY_LAST = BUSY_CNT_W'(MDU_TIMEOUT - 1);

    stall_state_e            state_q, state_d;
    logic [BUSY_CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic                    mdu_err_q, mdu_err_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    stage_ctl_t              ctl;
    logic                    load_use;

    load_use_detect u_load_use_detect (
        .id_ex_memread (bus.id_ex_memread),
        .id_ex_rt      (bus.id_ex_rt),
        .id_rs         (bus.id_rs),
        .id_rt         (bus.id_rt),
        .id_uses_rt    (bus.id_uses_rt),
        .hazard        (load_use)
    );

    // Stage controls and next state; outputs follow state and inputs with no latency
    always_comb begin
        ctl        = CTL_OFF;
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        mdu_err_d  = mdu_err_q;
        if (rst) begin
            case (state_q)
                RUN: begin
                    ctl = CTL_FLOW;
                    if (bus.pcsrc) begin
                        // Taken branch kills everything younger, including an MDU op in EX
                        ctl.if_id_flush  = 1'b1;
                        ctl.id_ex_flush  = 1'b1;
                        ctl.ex_mem_flush = 1'b1;
                    end else if (bus.ex_mdu_op) begin
                        // Freeze front end, bubble into MEM so MEM/WB drain
                        ctl            = CTL_OFF;
                        ctl.mdu_start    = 1'b1;
                        ctl.ex_mem_flush = 1'b1;
                        state_d    = MDU_BUSY;
                        busy_cnt_d = '0;
                    end else if (load_use) begin
                        ctl.pc_en       = 1'b0;
                        ctl.if_id_en    = 1'b0;
                        ctl.id_ex_flush = 1'b1;
                    end else if (bus.id_jump) begin
                        ctl.if_id_flush = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    ctl.ex_mem_flush = 1'b1;
                    busy_cnt_d       = busy_cnt_q + 1'b1;
                    if (bus.mdu_done || (busy_cnt_q == BUSY_LAST)) begin
                        // Release: EX_MEM captures the (possibly aborted) result
                        ctl     = CTL_FLOW;
                        state_d = RUN;
                        if (!bus.mdu_done) begin
                            mdu_err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles where the PC is held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctl.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, busy timer, sticky error and performance counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            busy_cnt_q  <= '0;
            mdu_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            mdu_err_q   <= mdu_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_en        = ctl.pc_en;
    assign bus.if_id_en     = ctl.if_id_en;
    assign bus.id_ex_en     = ctl.id_ex_en;
    assign bus.ex_mem_en    = ctl.ex_mem_en;
    assign bus.if_id_flush  = ctl.if_id_flush;
    assign bus.id_ex_flush  = ctl.id_ex_flush;
    assign bus.ex_mem_flush = ctl.ex_mem_flush;
    assign bus.mdu_start    = ctl.mdu_start;
    assign bus.mdu_err      = mdu_err_q;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule : pipe_stall_ctl
`default_nettype wire

// File: tb/tb_pipe_stall_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctl
//  Description : Self-checking bench for pipe_stall_ctl with a scoreboard of
//                expected stage controls, error flag and stall count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stall_ctl;

    localparam int TO = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pipe_stall_ctl_if #(.CNT_W(CW)) bus ();

    pipe_stall_ctl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       rst;
        logic       pcsrc;
        logic       mdu;
        logic       memread;
        logic [4:0] exrt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       done;
    } stim_t;

    typedef struct packed {
        logic [7:0]    ctl;   // {pc,if_id,id_ex,ex_mem en, if_id,id_ex,ex_mem flush, start}
        logic          err;
        logic [CW-1:0] stall;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state
    logic          m_busy_st;
    int            m_busy;
    logic          m_err;
    logic [CW-1:0] m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_ctl(input stim_t s);
        if (!s.rst) return 8'b0000_0000;
        if (m_busy_st) begin
            if (s.done || (m_busy == TO - 1)) return 8'b1111_0000;
            return 8'b0000_0010;
        end
        if (s.pcsrc) return 8'b1111_1110;
        if (s.mdu)   return 8'b0000_0011;
        if (s.memread && (s.exrt != 5'd0) &&
            ((s.exrt == s.rs) || (s.uses_rt && (s.exrt == s.rt)))) return 8'b0011_0100;
        if (s.jump)  return 8'b1111_1000;
        return 8'b1111_0000;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // One pipeline cycle: drive, predict, compare at negedge, advance model
    task automatic apply(input stim_t s, input string tag);
        exp_t       e;
        logic [7:0] got;
        rst               = s.rst;
        bus.pcsrc         = s.pcsrc;
        bus.ex_mdu_op     = s.mdu;
        bus.id_ex_memread = s.memread;
        bus.id_ex_rt      = s.exrt;
        bus.id_rs         = s.rs;
        bus.id_rt         = s.rt;
        bus.id_uses_rt    = s.uses_rt;
        bus.id_jump       = s.jump;
        bus.mdu_done      = s.done;
        if (!s.rst) begin
            m_busy_st = 1'b0;
            m_busy    = 0;
            m_err     = 1'b0;
            m_stall   = '0;
        end
        e.ctl   = model_ctl(s);
        e.err   = m_err;
        e.stall = m_stall;
        sb.push_back(e);

        @(negedge clk);
        got = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
               bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mdu_start};
        e = sb.pop_front();
        check({tag, ".ctl"},   {24'd0, got},           {24'd0, e.ctl});
        check({tag, ".err"},   {31'd0, bus.mdu_err},   {31'd0, e.err});
        check({tag, ".stall"}, {16'd0, bus.stall_cnt}, {16'd0, e.stall});

        @(posedge clk);
        #1;
        if (s.rst) begin
            if (m_busy_st) begin
                if (s.done || (m_busy == TO - 1)) begin
                    m_busy_st = 1'b0;
                    if (!s.done) m_err = 1'b1;
                end else begin
                    m_busy++;
                end
            end else if (!s.pcsrc && s.mdu) begin
                m_busy_st = 1'b1;
                m_busy    = 0;
            end
            if (!e.ctl[7] && (m_stall != {CW{1'b1}})) m_stall++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;

        // Reset held
        s = idle(); s.rst = 1'b0;
        apply(s, "rst0");
        apply(s, "rst1");

        // Free running
        s = idle();
        apply(s, "run");

        // lw $2 ; add $3,$2,$4 -> one bubble
        s = idle(); s.memread = 1'b1; s.exrt = 5'd2; s.rs = 5'd2; s.rt = 5'd4; s.uses_rt = 1'b1;
        apply(s, "lu_rs");
        s = idle(); s.rs = 5'd2; s.rt = 5'd4; s.uses_rt = 1'b1;
        apply(s, "lu_after");

        // Dependency through rt
        s = idle(); s.memread = 1'b1; s.exrt = 5'd7; s.rs = 5'd1; s.rt = 5'd7; s.uses_rt = 1'b1;
        apply(s, "lu_rt");
        // rt matches but not read
        s = idle(); s.memread = 1'b1; s.exrt = 5'd7; s.rs = 5'd1; s.rt = 5'd7; s.uses_rt = 1'b0;
        apply(s, "lu_rt_unused");
        // lw $0 ; add $3,$0,$4
        s = idle(); s.memread = 1'b1; s.exrt = 5'd0; s.rs = 5'd0; s.rt = 5'd4; s.uses_rt = 1'b1;
        apply(s, "lu_zero");
        // lw $2 ; j
        s = idle(); s.memread = 1'b1; s.exrt = 5'd2; s.rs = 5'd0; s.rt = 5'd2; s.jump = 1'b1;
        apply(s, "lw_jump");
        // Non-load in EX, same register
        s = idle(); s.exrt = 5'd2; s.rs = 5'd2;
        apply(s, "no_load");

        // Taken branch beats MDU op
        s = idle(); s.pcsrc = 1'b1; s.mdu = 1'b1;
        apply(s, "br_mdu");
        s = idle();
        apply(s, "br_after");

        // Done pulse in RUN ignored
        s = idle(); s.done = 1'b1;
        apply(s, "done_run");

        // mult with done on the fifth cycle after start
        s = idle(); s.mdu = 1'b1;
        apply(s, "mult_start");
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.mdu = 1'b1; s.done = (i == 4);
            s.pcsrc = (i == 1); // ignored while busy
            apply(s, $sformatf("mult_busy%0d", i));
        end
        s = idle();
        apply(s, "mult_after");

        // Timeout: no done
        s = idle(); s.mdu = 1'b1;
        apply(s, "to_start");
        for (int i = 0; i < TO; i++) begin
            s = idle(); s.mdu = 1'b1;
            apply(s, $sformatf("to_busy%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            s = idle();
            apply(s, $sformatf("to_sticky%0d", i));
        end

        // Reset in the middle of a busy period
        s = idle(); s.mdu = 1'b1;
        apply(s, "rb_start");
        apply(s, "rb_busy0");
        apply(s, "rb_busy1");
        s.rst = 1'b0;
        apply(s, "rb_rst");
        s = idle();
        apply(s, "rb_run");
        s = idle(); s.memread = 1'b1; s.exrt = 5'd9; s.rs = 5'd9;
        apply(s, "rb_lu");
        s = idle();
        apply(s, "rb_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_stall_ctl
`default_nettype wire
